// File: rtl/pipe_hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_hazard_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2
  } chan_state_t;

  localparam int unsigned STG_PC    = 0;
  localparam int unsigned STG_IFID  = 1;
  localparam int unsigned STG_IDEX  = 2;
  localparam int unsigned STG_EXMEM = 3;
  localparam int unsigned STG_MEMWB = 4;

  // Width of a wait counter that must hold the value TIMEOUT (min 1 bit).
  function automatic int unsigned wait_cnt_width(input int unsigned timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_chan_fsm.sv
// One memory request channel: IDLE/WAIT/GRANT tracking, wait counter and
// sticky timeout flag.
module mem_chan_fsm
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic complete,
  input  logic freeze,
  output logic stall,
  output logic grant,
  output logic timeout_err
);

  localparam int unsigned      CW   = wait_cnt_width(TIMEOUT);
  localparam logic [CW-1:0]    TMAX = CW'(TIMEOUT);

  chan_state_t       state, state_nxt;
  logic [CW-1:0]     wait_cnt, wait_cnt_nxt;
  logic              err_nxt;

  // State, wait counter and sticky error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      wait_cnt    <= wait_cnt_nxt;
      timeout_err <= err_nxt;
    end
  end

  // Next state, stall/grant outputs and wait-counter update.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = '0;
    err_nxt      = timeout_err;
    stall        = 1'b0;
    grant        = 1'b0;

    unique case (state)
      IDLE: begin
        stall = req && !complete;
        if (req) state_nxt = complete ? GRANT : WAIT;
      end
      WAIT: begin
        stall = req && !complete;
        if (complete)  state_nxt = GRANT;
        else if (!req) state_nxt = IDLE;
      end
      GRANT: begin
        grant = 1'b1;
        if (!freeze || !req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // The request cycle that enters WAIT already counts as a wait cycle, so
    // the counter starts at 1 and the flag is visible after TIMEOUT stall cycles.
    if (TIMEOUT != 0 && state_nxt == WAIT) begin
      if (state == IDLE)       wait_cnt_nxt = CW'(1);
      else if (wait_cnt == TMAX) wait_cnt_nxt = wait_cnt;
      else                     wait_cnt_nxt = wait_cnt + CW'(1);
      if (wait_cnt_nxt == TMAX) err_nxt = 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/bubble controller: freezes all stages while any memory
// channel waits, inserts load/store bubbles, and counts stall/bubble cycles.
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 5,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned HOLD_STAGES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     mem_req,
  input  logic [NUM_CH-1:0]     mem_complete,
  input  logic                  ex_mem_access,
  output logic [NUM_STAGES-1:0] stage_we,
  output logic                  bubble,
  output logic                  freeze,
  output logic [NUM_CH-1:0]     chan_grant,
  output logic [NUM_CH-1:0]     timeout_err,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      bubble_cycles
);

  logic [NUM_CH-1:0] stall;
  logic [NUM_CH-1:0] grant;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    mem_chan_fsm #(
      .TIMEOUT (TIMEOUT)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .req         (mem_req[c]),
      .complete    (mem_complete[c]),
      .freeze      (freeze),
      .stall       (stall[c]),
      .grant       (grant[c]),
      .timeout_err (timeout_err[c])
    );
  end

  // Enable/bubble priority: reset > freeze > bubble > pass-through.
  always_comb begin
    freeze     = 1'b0;
    bubble     = 1'b0;
    stage_we   = '1;
    chan_grant = '0;
    if (!reset) begin
      chan_grant = grant;
      if (|stall) begin
        freeze   = 1'b1;
        stage_we = '0;
      end else if (ex_mem_access) begin
        bubble = 1'b1;
        stage_we[STG_PC +: HOLD_STAGES] = '0;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles  <= '0;
      bubble_cycles <= '0;
    end else begin
      if (freeze && stall_cycles != '1)  stall_cycles  <= stall_cycles + CNT_W'(1);
      if (bubble && bubble_cycles != '1) bubble_cycles <= bubble_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mem_req;
  logic [1:0] mem_complete;
  logic       ex_mem_access;

  logic [4:0]  stage_we;
  logic        bubble, freeze;
  logic [1:0]  chan_grant, timeout_err;
  logic [15:0] stall_cycles, bubble_cycles;

  logic [4:0]  s_stage_we;
  logic        s_bubble, s_freeze;
  logic [1:0]  s_chan_grant, s_timeout_err;
  logic [2:0]  s_stall_cycles, s_bubble_cycles;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_hazard_ctrl #(
    .NUM_STAGES (5), .NUM_CH (2), .HOLD_STAGES (2), .CNT_W (16), .TIMEOUT (8)
  ) dut (
    .clk (clk), .reset (reset), .mem_req (mem_req), .mem_complete (mem_complete),
    .ex_mem_access (ex_mem_access), .stage_we (stage_we), .bubble (bubble),
    .freeze (freeze), .chan_grant (chan_grant), .timeout_err (timeout_err),
    .stall_cycles (stall_cycles), .bubble_cycles (bubble_cycles)
  );

  // Narrow counters and timeout disabled, sharing the same stimulus.
  pipe_hazard_ctrl #(
    .NUM_STAGES (5), .NUM_CH (2), .HOLD_STAGES (2), .CNT_W (3), .TIMEOUT (0)
  ) dut_s (
    .clk (clk), .reset (reset), .mem_req (mem_req), .mem_complete (mem_complete),
    .ex_mem_access (ex_mem_access), .stage_we (s_stage_we), .bubble (s_bubble),
    .freeze (s_freeze), .chan_grant (s_chan_grant), .timeout_err (s_timeout_err),
    .stall_cycles (s_stall_cycles), .bubble_cycles (s_bubble_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_req = '0; mem_complete = '0; ex_mem_access = 1'b0;
    next();
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; mem_req = '0; mem_complete = '0; ex_mem_access = 1'b0;
    next();
    // Inputs active during reset must not leak to the outputs
    mem_req = 2'b11; ex_mem_access = 1'b1;
    mid();
    check("rst_we",     stage_we,     5'b11111);
    check("rst_freeze", freeze,       1'b0);
    check("rst_bubble", bubble,       1'b0);
    check("rst_grant",  chan_grant,   2'b00);
    check("rst_stall",  stall_cycles, 16'd0);
    check("rst_bubcnt", bubble_cycles,16'd0);
    check("rst_tmo",    timeout_err,  2'b00);
    next();
    do_reset();

    // T1: single channel wait, completion, request drop
    mid(); check("t1_idle_we", stage_we, 5'b11111); next();
    mem_req = 2'b01;
    for (int i = 0; i < 4; i++) begin
      mid();
      check("t1_freeze", freeze, 1'b1);
      check("t1_we",     stage_we, 5'b00000);
      next();
    end
    mem_complete = 2'b01;
    mid();
    check("t1_cmp_we",    stage_we,   5'b11111);
    check("t1_cmp_frz",   freeze,     1'b0);
    check("t1_cmp_grant", chan_grant, 2'b00);
    next();
    mem_complete = '0; mem_req = '0;
    mid();
    check("t1_grant",    chan_grant, 2'b01);
    check("t1_grant_we", stage_we,   5'b11111);
    next();
    mid();
    check("t1_grant_off", chan_grant,    2'b00);
    check("t1_stall",     stall_cycles,  16'd4);
    check("t1_bubcnt",    bubble_cycles, 16'd0);
    next();
    do_reset();

    // T2: two channels, early completion on ch0 holds GRANT under freeze
    mem_req = 2'b11;
    for (int i = 0; i < 2; i++) begin
      mid(); check("t2_frz_a", freeze, 1'b1); check("t2_grant_a", chan_grant, 2'b00); next();
    end
    mem_complete = 2'b01;
    mid(); check("t2_frz_c0", freeze, 1'b1); next();
    mem_complete = '0;
    for (int i = 0; i < 4; i++) begin
      mid(); check("t2_frz_b", freeze, 1'b1); check("t2_grant_b", chan_grant, 2'b01); next();
    end
    mem_complete = 2'b10;
    mid();
    check("t2_rel_frz",   freeze,     1'b0);
    check("t2_rel_we",    stage_we,   5'b11111);
    check("t2_rel_grant", chan_grant, 2'b01);
    next();
    mem_complete = '0; mem_req = '0;
    mid(); check("t2_grant_c1", chan_grant, 2'b10); next();
    mid();
    check("t2_grant_off", chan_grant,   2'b00);
    check("t2_stall",     stall_cycles, 16'd7);
    next();
    do_reset();

    // T3: lone bubble
    ex_mem_access = 1'b1;
    mid();
    check("t3_we",     stage_we, 5'b11100);
    check("t3_bubble", bubble,   1'b1);
    check("t3_frz",    freeze,   1'b0);
    next();
    ex_mem_access = 1'b0;
    mid();
    check("t3_we_after", stage_we,      5'b11111);
    check("t3_bub_off",  bubble,        1'b0);
    check("t3_bubcnt",   bubble_cycles, 16'd1);
    next();
    do_reset();

    // T4: bubble request suppressed by freeze, asserts on completion cycle
    mem_req = 2'b10; ex_mem_access = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mid(); check("t4_bub_frz", bubble, 1'b0); check("t4_we_frz", stage_we, 5'b00000); next();
    end
    mem_complete = 2'b10;
    mid(); check("t4_bub_cmp", bubble, 1'b1); check("t4_we_cmp", stage_we, 5'b11100); next();
    mem_complete = '0; mem_req = '0; ex_mem_access = 1'b0;
    mid();
    check("t4_grant",  chan_grant,    2'b10);
    check("t4_bubcnt", bubble_cycles, 16'd1);
    check("t4_stall",  stall_cycles,  16'd2);
    next();
    do_reset();

    // T5: timeout after 8 stall cycles, sticky through completion, reset clears
    mem_req = 2'b01;
    for (int i = 0; i < 8; i++) begin
      mid(); check("t5_tmo_low", timeout_err, 2'b00); next();
    end
    mid();
    check("t5_tmo_set",   timeout_err,   2'b01);
    check("t5_frz_still", freeze,        1'b1);
    check("t5_s_tmo_off", s_timeout_err, 2'b00);
    next();
    mem_complete = 2'b01;
    mid(); next();
    mem_complete = '0; mem_req = '0;
    mid();
    check("t5_tmo_sticky", timeout_err,    2'b01);
    check("t5_stall",      stall_cycles,   16'd9);
    check("t5_s_sat",      s_stall_cycles, 3'd7);
    next();
    do_reset();
    mid(); check("t5_tmo_clr", timeout_err, 2'b00); next();

    // T6: reset during WAIT with the request still high
    mem_req = 2'b01;
    for (int i = 0; i < 3; i++) begin mid(); next(); end
    reset = 1'b1;
    mid();
    check("t6_rst_frz", freeze,   1'b0);
    check("t6_rst_we",  stage_we, 5'b11111);
    next();
    reset = 1'b0;
    mid();
    check("t6_frz",   freeze,       1'b1);
    check("t6_we",    stage_we,     5'b00000);
    check("t6_stall", stall_cycles, 16'd0);
    check("t6_tmo",   timeout_err,  2'b00);
    next();
    mid();
    check("t6_frz2",   freeze,       1'b1);
    check("t6_stall2", stall_cycles, 16'd1);
    next();
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
